// File: rtl/lab3_mem_line_mem_responder.sv
// Memory-side responder for the 16B cache-line protocol: a single-outstanding
// READ/WRITE/INIT responder backed by a line array, with programmable latency.
module lab3_mem_line_mem_responder #(
    parameter int p_num_lines = 256,
    parameter int p_latency   = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         memreq_val,
    output logic         memreq_rdy,
    input  logic [182:0] memreq_msg,
    output logic         memresp_val,
    input  logic         memresp_rdy,
    output logic [146:0] memresp_msg
);

    localparam int         c_idw = $clog2(p_num_lines);
    localparam logic [3:0] c_lat = 4'(p_latency);

    localparam logic [2:0] c_type_read  = 3'd0;
    localparam logic [2:0] c_type_write = 3'd1;
    localparam logic [2:0] c_type_init  = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Message fields are packed right-aligned; the unused top bits of each
    // message are ignored on requests and driven to zero on responses.
    function automatic logic [146:0] build_resp(
        input logic [2:0]   rtype,
        input logic [7:0]   ropaque,
        input logic [3:0]   rlen,
        input logic [127:0] rline
    );
        logic [127:0] data;
        if (rtype == c_type_read) begin
            data = rline;
        end else begin
            data = 128'd0;
        end
        return {2'b00, rtype, ropaque, 2'b00, rlen, data};
    endfunction

    // Byte-masked merge: len=0 replaces the whole line, len=n the low n bytes.
    function automatic logic [127:0] merge_line(
        input logic [127:0] old_line,
        input logic [127:0] new_data,
        input logic [3:0]   wlen
    );
        logic [127:0] res;
        res = old_line;
        for (int b = 0; b < 16; b++) begin
            if ((wlen == 4'd0) || (4'(b) < wlen)) begin
                res[b*8 +: 8] = new_data[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = old_line[b*8 +: 8];
            end
        end
        return res;
    endfunction

    logic [2:0]   req_type_s;
    logic [7:0]   req_opaque_s;
    logic [31:0]  req_addr_s;
    logic [3:0]   req_len_s;
    logic [127:0] req_data_s;
    logic [c_idw-1:0] req_idx_s;

    assign req_type_s   = memreq_msg[174:172];
    assign req_opaque_s = memreq_msg[171:164];
    assign req_addr_s   = memreq_msg[163:132];
    assign req_len_s    = memreq_msg[131:128];
    assign req_data_s   = memreq_msg[127:0];
    assign req_idx_s    = req_addr_s[4 +: c_idw];

    logic unused_ok_s;
    assign unused_ok_s = ^{memreq_msg[182:175], req_addr_s};

    logic [127:0] mem_array [p_num_lines];

    state_t           state_q,    state_d;
    logic [3:0]       cnt_q,      cnt_d;
    logic [2:0]       type_q,     type_d;
    logic [7:0]       opaque_q,   opaque_d;
    logic [3:0]       len_q,      len_d;
    logic [c_idw-1:0] idx_q,      idx_d;
    logic             req_rdy_q,  req_rdy_d;
    logic             resp_val_q, resp_val_d;
    logic [146:0]     resp_msg_q, resp_msg_d;

    logic             accept_s;
    logic             wr_en_s;
    logic [c_idw-1:0] rd_idx_s;
    logic [127:0]     rd_line_s;
    logic [127:0]     wr_line_s;

    // Read port: the incoming index while idle, the latched index afterwards.
    always_comb begin
        if (state_q == ST_IDLE) begin
            rd_idx_s = req_idx_s;
        end else begin
            rd_idx_s = idx_q;
        end
        rd_line_s = mem_array[rd_idx_s];
        wr_line_s = merge_line(rd_line_s, req_data_s, req_len_s);
    end

    // Next-state, latched request fields, array write enable and response build.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        type_d     = type_q;
        opaque_d   = opaque_q;
        len_d      = len_q;
        idx_d      = idx_q;
        resp_msg_d = resp_msg_q;
        wr_en_s    = 1'b0;
        accept_s   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                accept_s = memreq_val & req_rdy_q;
                if (accept_s) begin
                    type_d   = req_type_s;
                    opaque_d = req_opaque_s;
                    len_d    = req_len_s;
                    idx_d    = req_idx_s;
                    if ((req_type_s == c_type_write) || (req_type_s == c_type_init)) begin
                        wr_en_s = 1'b1;
                    end else begin
                        wr_en_s = 1'b0;
                    end
                    if (c_lat == 4'd0) begin
                        state_d    = ST_RESP;
                        cnt_d      = 4'd0;
                        resp_msg_d = build_resp(req_type_s, req_opaque_s, req_len_s, rd_line_s);
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = c_lat;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d    = ST_RESP;
                    cnt_d      = 4'd0;
                    resp_msg_d = build_resp(type_q, opaque_q, len_q, rd_line_s);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_val_q & memresp_rdy) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        req_rdy_d  = (state_d == ST_IDLE);
        resp_val_d = (state_d == ST_RESP);
    end

    // Control and response registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            type_q     <= 3'd0;
            opaque_q   <= 8'd0;
            len_q      <= 4'd0;
            idx_q      <= '0;
            req_rdy_q  <= 1'b0;
            resp_val_q <= 1'b0;
            resp_msg_q <= 147'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            type_q     <= type_d;
            opaque_q   <= opaque_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            req_rdy_q  <= req_rdy_d;
            resp_val_q <= resp_val_d;
            resp_msg_q <= resp_msg_d;
        end
    end

    // Backing line array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_array[req_idx_s] <= wr_line_s;
        end
    end

    assign memreq_rdy  = req_rdy_q;
    assign memresp_val = resp_val_q;
    assign memresp_msg = resp_msg_q;

endmodule

// File: tb/tb_lab3_mem_line_mem_responder.sv
// Scoreboard bench: two responders (latency 3 and latency 0) driven with
// directed transactions; a monitor compares every response handshake.
module tb_lab3_mem_line_mem_responder;

    localparam logic [2:0] T_READ  = 3'd0;
    localparam logic [2:0] T_WRITE = 3'd1;
    localparam logic [2:0] T_INIT  = 3'd2;

    localparam logic [127:0] RAMP  = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] ONES  = {128{1'b1}};
    localparam logic [127:0] DPAT  = 128'hA5A5A5A5_12345678_CAFEF00D_01020304;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         req_val  [2];
    logic         req_rdy  [2];
    logic [182:0] req_msg  [2];
    logic         resp_val [2];
    logic         resp_rdy [2];
    logic [146:0] resp_msg [2];

    int tests = 0;
    int fails = 0;
    logic [146:0] exp_q0 [$];
    logic [146:0] exp_q1 [$];

    lab3_mem_line_mem_responder #(.p_num_lines(256), .p_latency(3)) u_lat3 (
        .clk(clk), .reset(rst_n),
        .memreq_val(req_val[0]), .memreq_rdy(req_rdy[0]), .memreq_msg(req_msg[0]),
        .memresp_val(resp_val[0]), .memresp_rdy(resp_rdy[0]), .memresp_msg(resp_msg[0])
    );

    lab3_mem_line_mem_responder #(.p_num_lines(256), .p_latency(0)) u_lat0 (
        .clk(clk), .reset(rst_n),
        .memreq_val(req_val[1]), .memreq_rdy(req_rdy[1]), .memreq_msg(req_msg[1]),
        .memresp_val(resp_val[1]), .memresp_rdy(resp_rdy[1]), .memresp_msg(resp_msg[1])
    );

    function automatic logic [182:0] pack_req(input logic [2:0] t, input logic [7:0] op,
                                              input logic [31:0] a, input logic [3:0] l,
                                              input logic [127:0] d);
        return {8'h00, t, op, a, l, d};
    endfunction

    function automatic logic [146:0] exp_resp(input logic [2:0] t, input logic [7:0] op,
                                              input logic [3:0] l, input logic [127:0] d);
        return {2'b00, t, op, 2'b00, l, d};
    endfunction

    task automatic chk(input string name, input logic [146:0] act, input logic [146:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every response handshake is popped against the scoreboard.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst_n && resp_val[d] && resp_rdy[d]) begin
                if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_resp dut%0d: got %h expected none", d, resp_msg[d]);
                end else if (d == 0) begin
                    chk("resp_dut0", resp_msg[0], exp_q0.pop_front());
                end else begin
                    chk("resp_dut1", resp_msg[1], exp_q1.pop_front());
                end
            end
        end
    end

    // Called at posedge+#1; returns at posedge+#1 of the cycle after the accept edge.
    task automatic send(input int d, input logic [2:0] t, input logic [7:0] op,
                        input logic [31:0] a, input logic [3:0] l, input logic [127:0] dat,
                        input logic [127:0] ed, input bit push);
        int n;
        n = 0;
        req_msg[d] = pack_req(t, op, a, l, dat);
        req_val[d] = 1'b1;
        if (push) begin
            if (d == 0) exp_q0.push_back(exp_resp(t, op, l, ed));
            else        exp_q1.push_back(exp_resp(t, op, l, ed));
        end
        @(negedge clk);
        while (!req_rdy[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_rdy[d]) begin
            tests++;
            fails++;
            $display("FAIL send_timeout dut%0d: got rdy=0 expected rdy=1 within 100 cycles", d);
        end
        @(posedge clk);
        #1;
        req_val[d] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 147'(exp_q0.size() + exp_q1.size()), 147'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int n;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_val[d]  = 1'b0;
            req_msg[d]  = 183'd0;
            resp_rdy[d] = 1'b1;
        end

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_val0", 147'(resp_val[0]), 147'd0);
        chk("rst_rdy0", 147'(req_rdy[0]), 147'd0);
        chk("rst_msg0", resp_msg[0], 147'd0);
        chk("rst_rdy1", 147'(req_rdy[1]), 147'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_rdy0", 147'(req_rdy[0]), 147'd1);
        chk("post_rst_rdy1", 147'(req_rdy[1]), 147'd1);

        // 1. INIT then READ of a ramp line
        send(0, T_INIT, 8'h01, 32'h0000_0040, 4'd0, RAMP, 128'd0, 1'b1);
        send(0, T_READ, 8'h5A, 32'h0000_0040, 4'd0, 128'd0, RAMP, 1'b1);
        drain();

        // 2. Latency 3: valid low for three cycles, high on the fourth
        send(0, T_READ, 8'h11, 32'h0000_0040, 4'd0, 128'd0, RAMP, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("lat_val_low", 147'(resp_val[0]), 147'd0);
            chk("lat_rdy_low", 147'(req_rdy[0]), 147'd0);
        end
        @(negedge clk);
        chk("lat_val_high", 147'(resp_val[0]), 147'd1);
        chk("lat_rdy_resp", 147'(req_rdy[0]), 147'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("lat_rdy_back", 147'(req_rdy[0]), 147'd1);
        @(posedge clk);
        #1;

        // 3. Backpressure: stable response, requests ignored
        resp_rdy[0] = 1'b0;
        send(0, T_READ, 8'h22, 32'h0000_0040, 4'd0, 128'd0, RAMP, 1'b1);
        n = 0;
        while (!resp_val[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_val_arrives", 147'(resp_val[0]), 147'd1);
        @(posedge clk);
        #1;
        req_msg[0] = pack_req(T_WRITE, 8'hEE, 32'h0000_0040, 4'd0, 128'd0);
        req_val[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_val", 147'(resp_val[0]), 147'd1);
            chk("bp_msg", resp_msg[0], exp_resp(T_READ, 8'h22, 4'd0, RAMP));
            chk("bp_req_rdy", 147'(req_rdy[0]), 147'd0);
            @(posedge clk);
            #1;
        end
        req_val[0] = 1'b0;
        resp_rdy[0] = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_idle_rdy", 147'(req_rdy[0]), 147'd1);
        chk("bp_idle_val", 147'(resp_val[0]), 147'd0);
        @(posedge clk);
        #1;

        // 4. Partial write into an all-ones line; ignored write left 0x40 intact
        send(0, T_INIT, 8'h02, 32'h0000_0080, 4'd0, ONES, 128'd0, 1'b1);
        send(0, T_WRITE, 8'h03, 32'h0000_0080, 4'd4, 128'hDEADBEEF, 128'd0, 1'b1);
        send(0, T_READ, 8'h04, 32'h0000_0080, 4'd0, 128'd0,
             {96'hFFFFFFFF_FFFFFFFF_FFFFFFFF, 32'hDEADBEEF}, 1'b1);
        send(0, T_READ, 8'h05, 32'h0000_0040, 4'd0, 128'd0, RAMP, 1'b1);
        drain();

        // 5. Aliasing, len=15 boundary, unsupported type on the zero-latency unit
        send(1, T_WRITE, 8'h10, 32'h0000_1000, 4'd0, DPAT, 128'd0, 1'b1);
        send(1, T_READ, 8'h11, 32'h0000_0000, 4'd0, 128'd0, DPAT, 1'b1);
        send(1, T_INIT, 8'h12, 32'h0000_1010, 4'd0, ONES, 128'd0, 1'b1);
        send(1, T_WRITE, 8'h13, 32'h0000_1010, 4'd15, 128'd0, 128'd0, 1'b1);
        send(1, T_READ, 8'h14, 32'h0000_0010, 4'd0, 128'd0, {8'hFF, 120'd0}, 1'b1);
        send(1, 3'd5, 8'h15, 32'h0000_0010, 4'd0, RAMP, 128'd0, 1'b1);
        send(1, T_READ, 8'h16, 32'h0000_0010, 4'd7, 128'd0, {8'hFF, 120'd0}, 1'b1);
        drain();

        // 5b. Zero latency sustains one transaction every two cycles
        req_msg[1] = pack_req(T_READ, 8'h77, 32'h0000_0000, 4'd0, 128'd0);
        req_val[1] = 1'b1;
        acc = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_rdy[1]) begin
                acc++;
                exp_q1.push_back(exp_resp(T_READ, 8'h77, 4'd0, DPAT));
            end
        end
        @(posedge clk);
        #1;
        req_val[1] = 1'b0;
        chk("throughput_accepts", 147'(acc), 147'd10);
        drain();

        // 6. Reset mid-WAIT drops the transaction; array contents survive
        send(0, T_READ, 8'h33, 32'h0000_0040, 4'd0, 128'd0, RAMP, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_val", 147'(resp_val[0]), 147'd0);
        chk("midrst_rdy", 147'(req_rdy[0]), 147'd0);
        chk("midrst_msg", resp_msg[0], 147'd0);
        chk("midrst_msg1", resp_msg[1], 147'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rel_rdy", 147'(req_rdy[0]), 147'd1);
        chk("rel_val", 147'(resp_val[0]), 147'd0);
        @(posedge clk);
        #1;
        send(0, T_READ, 8'h34, 32'h0000_0040, 4'd0, 128'd0, RAMP, 1'b1);
        drain();
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
